// File: rtl/ptw_resp_router_pkg.sv
// Shared definitions for the PTW response router slice.
//   NUM_REQ        : number of TLB requesters sharing the walker
//   PPN_W_DEFAULT  : default physical-page-number width
//   ptw_resp_t     : PTW response payload at the default PPN width
package ptw_resp_router_pkg;

    localparam int NUM_REQ       = 2;
    localparam int PPN_W_DEFAULT = 20;

    typedef struct packed {
        logic [PPN_W_DEFAULT-1:0] ppn;
        logic                     pf;
        logic                     ae;
    } ptw_resp_t;

endpackage

// File: rtl/ptw_tag_fifo.sv
// Width-1 circular FIFO holding the grant tag of each outstanding request.
//   clock, reset      : rising-edge clock, async active-high reset
//   push / wr_data    : write request and tag (ignored when full)
//   pop  / rd_data    : read request (ignored when empty) and head tag
//   full, empty, count: occupancy status, all from registered count
module ptw_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     wr_data,
    input  logic                     pop,
    output logic                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ptw_resp_router.sv
// Steers in-order PTW responses back to the requester that won the
// matching arbiter grant, and flags protocol violations.
//   clock, reset                 : rising-edge clock, async active-high reset
//   io_req_fire / io_req_chosen  : accepted arbiter handshake and its grant index
//   io_req_ready                 : tag FIFO has room (gates the arbiter)
//   io_resp_*                    : PTW response channel
//   io_out_0_* / io_out_1_*      : registered one-cycle response pulse per requester
//   io_err_orphan                : sticky protocol-violation flag
module ptw_resp_router
    import ptw_resp_router_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PPN_W = PPN_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_fire,
    input  logic             io_req_chosen,
    output logic             io_req_ready,
    input  logic             io_resp_valid,
    input  logic [PPN_W-1:0] io_resp_bits_ppn,
    input  logic             io_resp_bits_pf,
    input  logic             io_resp_bits_ae,
    output logic             io_resp_ready,
    output logic             io_out_0_valid,
    output logic [PPN_W-1:0] io_out_0_bits_ppn,
    output logic             io_out_0_bits_pf,
    output logic             io_out_0_bits_ae,
    output logic             io_out_1_valid,
    output logic [PPN_W-1:0] io_out_1_bits_ppn,
    output logic             io_out_1_bits_pf,
    output logic             io_out_1_bits_ae,
    output logic             io_err_orphan
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic               tag_full;
    logic               tag_empty;
    logic               head_tag;
    logic [CW-1:0]      tag_count;
    logic               push;
    logic               pop;
    logic               violation;

    logic [NUM_REQ-1:0] out_valid_q;
    logic [PPN_W-1:0]   ppn_q;
    logic               pf_q;
    logic               ae_q;
    logic               err_q;

    assign io_req_ready  = ~tag_full;
    assign io_resp_ready = ~tag_empty;
    assign push          = io_req_fire & ~tag_full;
    assign pop           = io_resp_valid & ~tag_empty;

    // Dropped response (nothing outstanding) or dropped tag (FIFO full).
    assign violation = (io_resp_valid & (tag_count == '0)) |
                       (io_req_fire & (tag_count == FULL_CNT));

    ptw_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (io_req_chosen),
        .pop     (pop),
        .rd_data (head_tag),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    // Payload is shared by both ports; only the valid selects the owner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= '0;
            ppn_q       <= '0;
            pf_q        <= 1'b0;
            ae_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (pop) begin
                out_valid_q <= NUM_REQ'(1) << head_tag;
                ppn_q       <= io_resp_bits_ppn;
                pf_q        <= io_resp_bits_pf;
                ae_q        <= io_resp_bits_ae;
            end else begin
                out_valid_q <= '0;
            end
            if (violation) begin
                err_q <= 1'b1;
            end
        end
    end

    assign io_out_0_valid    = out_valid_q[0];
    assign io_out_1_valid    = out_valid_q[1];
    assign io_out_0_bits_ppn = ppn_q;
    assign io_out_1_bits_ppn = ppn_q;
    assign io_out_0_bits_pf  = pf_q;
    assign io_out_1_bits_pf  = pf_q;
    assign io_out_0_bits_ae  = ae_q;
    assign io_out_1_bits_ae  = ae_q;
    assign io_err_orphan     = err_q;

endmodule
